// File: rtl/conv_8x32_pkg.sv
// Shared types and default widths for the convolution accumulator slice.
// The FSM state encoding lives here so the top and any debug tooling agree on it.
package conv_8x32_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } accum_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 20;
  localparam int DEF_MAX_TERMS  = 8;

endpackage

// File: rtl/conv_8x32_accum_if.sv
// Product-term input stream and accumulated-sample output stream (valid/ready both ways).
// slave: the accumulator; master: the term producer / result consumer.
interface conv_8x32_accum_if #(
  parameter int DATA_WIDTH = conv_8x32_pkg::DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = conv_8x32_pkg::DEF_ACC_WIDTH
);

  logic                      term_valid;
  logic                      term_ready;
  logic [2*DATA_WIDTH-1:0]   term_in;
  logic                      sum_valid;
  logic                      sum_ready;
  logic [ACC_WIDTH-1:0]      sum_out;
  logic                      ovf_out;

  modport slave (
    input  term_valid, term_in, sum_ready,
    output term_ready, sum_valid, sum_out, ovf_out
  );

  modport master (
    output term_valid, term_in, sum_ready,
    input  term_ready, sum_valid, sum_out, ovf_out
  );

endinterface

// File: rtl/conv_8x32_adder.sv
// Combinational unsigned W-bit adder exposing the carry out, used for acc + term.
// The carry is the overflow indication for the accumulator.
module conv_8x32_adder #(
  parameter int W = conv_8x32_pkg::DEF_ACC_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/conv_8x32_accum.sv
// Sums a programmed number of product terms into one output sample, with a sticky overflow flag.
// Define CONV_ACCUM_SAT_EN to saturate on overflow instead of wrapping.
module conv_8x32_accum
  import conv_8x32_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int MAX_TERMS  = DEF_MAX_TERMS,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_terms,
  output logic                 busy,
  conv_8x32_accum_if.slave     bus
);

  localparam int TERM_W = 2 * DATA_WIDTH;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCUM  = ACCUM;
  localparam logic [1:0] S_OUTPUT = OUTPUT;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     n_lat_q, n_lat_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] term_ext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_carry;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CNT_W-1:0]     n_clamped;
  logic                 term_xfer;

  assign term_ext  = {{(ACC_WIDTH - TERM_W){1'b0}}, bus.term_in};
  assign cnt_inc   = cnt_q + 1'b1;
  assign n_clamped = (n_terms > MAX_CNT) ? MAX_CNT : n_terms;
  assign term_xfer = (state_q == S_ACCUM) && bus.term_valid;

  conv_8x32_adder #(.W(ACC_WIDTH)) u_adder (
    .a     (acc_q),
    .b     (term_ext),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_lat_d = n_lat_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          n_lat_d = n_clamped;
          state_d = (n_terms == '0) ? S_OUTPUT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (term_xfer) begin
          ovf_d = ovf_q | add_carry;
`ifdef CONV_ACCUM_SAT_EN
          // Once saturated, stay pinned for the rest of the sample.
          acc_d = (add_carry || ovf_q) ? '1 : add_sum;
`else
          acc_d = add_sum;
`endif
          cnt_d = cnt_inc;
          if (cnt_inc == n_lat_q) begin
            state_d = S_OUTPUT;
          end
        end
      end
      S_OUTPUT: begin
        if (bus.sum_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      n_lat_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n_lat_q <= n_lat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.term_ready = (state_q == S_ACCUM);
  assign bus.sum_valid  = (state_q == S_OUTPUT);
  assign bus.sum_out    = acc_q;
  assign bus.ovf_out    = ovf_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_8x32_accum.sv
// Directed bench for conv_8x32_accum: a 20-bit instance for the main flows and a
// 16-bit instance for overflow; completed samples are checked against a scoreboard.
module tb_conv_8x32_accum;

  logic clk;
  logic rst;
  logic start_a, start_b;
  logic [3:0] n_a, n_b;
  logic busy_a, busy_b;

  int tests;
  int fails;

  typedef struct {
    logic [19:0] sum;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  conv_8x32_accum_if #(.DATA_WIDTH(8), .ACC_WIDTH(20)) a_if ();
  conv_8x32_accum_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) b_if ();

  conv_8x32_accum #(.DATA_WIDTH(8), .ACC_WIDTH(20), .MAX_TERMS(8)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .start   (start_a),
    .n_terms (n_a),
    .busy    (busy_a),
    .bus     (a_if.slave)
  );

  conv_8x32_accum #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MAX_TERMS(8)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .start   (start_b),
    .n_terms (n_b),
    .busy    (busy_b),
    .bus     (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [19:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [19:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    q_b.push_back(e);
  endtask

  // Scoreboard: every output handshake pops one expected sample.
  always @(negedge clk) begin
    if (!rst && a_if.sum_valid && a_if.sum_ready) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_sum", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_sb_sum", 32'(a_if.sum_out), 32'(e.sum));
        check("a_sb_ovf", 32'(a_if.ovf_out), 32'(e.ovf));
      end
    end
    if (!rst && b_if.sum_valid && b_if.sum_ready) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_sum", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_sb_sum", 32'(b_if.sum_out), 32'(e.sum));
        check("b_sb_ovf", 32'(b_if.ovf_out), 32'(e.ovf));
      end
    end
  end

  initial begin
    logic [15:0] t3 [3];
    logic [15:0] ovf_exp;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    start_a = 1'b0; n_a = '0; start_b = 1'b0; n_b = '0;
    a_if.term_valid = 1'b0; a_if.term_in = '0; a_if.sum_ready = 1'b1;
    b_if.term_valid = 1'b0; b_if.term_in = '0; b_if.sum_ready = 1'b1;
    tick();
    tick();
    check("rst_term_ready", 32'(a_if.term_ready), 32'd0);
    check("rst_sum_valid", 32'(a_if.sum_valid), 32'd0);
    check("rst_sum_out", 32'(a_if.sum_out), 32'd0);
    check("rst_ovf_out", 32'(a_if.ovf_out), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;

    // 1) four consecutive terms
    start_a = 1'b1; n_a = 4'd4;
    push_a(20'd100, 1'b0);
    tick();
    start_a = 1'b0;
    check("t1_term_ready", 32'(a_if.term_ready), 32'd1);
    check("t1_busy", 32'(busy_a), 32'd1);
    a_if.term_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_if.term_in = 16'(i * 10);
      tick();
      if (i < 4) check("t1_no_early_valid", 32'(a_if.sum_valid), 32'd0);
    end
    a_if.term_valid = 1'b0;
    check("t1_sum_valid", 32'(a_if.sum_valid), 32'd1);
    check("t1_sum_out", 32'(a_if.sum_out), 32'd100);
    check("t1_term_ready_drop", 32'(a_if.term_ready), 32'd0);
    tick();
    check("t1_valid_one_cycle", 32'(a_if.sum_valid), 32'd0);
    check("t1_idle", 32'(busy_a), 32'd0);

    // 2) term_valid gaps only advance on transfers
    start_a = 1'b1; n_a = 4'd3;
    push_a(20'd21, 1'b0);
    tick();
    start_a = 1'b0;
    a_if.term_valid = 1'b1; a_if.term_in = 16'd5; tick();
    a_if.term_valid = 1'b0; a_if.term_in = 16'd99; tick();
    a_if.term_valid = 1'b1; a_if.term_in = 16'd7; tick();
    a_if.term_valid = 1'b0; a_if.term_in = 16'd99; tick();
    check("t2_still_accum", 32'(a_if.term_ready), 32'd1);
    a_if.term_valid = 1'b1; a_if.term_in = 16'd9; tick();
    a_if.term_valid = 1'b0;
    check("t2_sum_valid", 32'(a_if.sum_valid), 32'd1);
    check("t2_sum_out", 32'(a_if.sum_out), 32'd21);
    tick();

    // 3) backpressure holds result; start ignored meanwhile
    a_if.sum_ready = 1'b0;
    start_a = 1'b1; n_a = 4'd2;
    push_a(20'd3, 1'b0);
    tick();
    start_a = 1'b0;
    a_if.term_valid = 1'b1; a_if.term_in = 16'd1; tick();
    a_if.term_in = 16'd2; tick();
    a_if.term_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start_a = 1'b1; n_a = 4'd4;
      tick();
      check("t3_hold_valid", 32'(a_if.sum_valid), 32'd1);
      check("t3_hold_sum", 32'(a_if.sum_out), 32'd3);
    end
    start_a = 1'b0;
    a_if.sum_ready = 1'b1;
    tick();
    check("t3_released", 32'(busy_a), 32'd0);

    // 5a) zero terms
    start_a = 1'b1; n_a = 4'd0;
    push_a(20'd0, 1'b0);
    tick();
    start_a = 1'b0;
    check("t5_zero_valid", 32'(a_if.sum_valid), 32'd1);
    check("t5_zero_sum", 32'(a_if.sum_out), 32'd0);
    tick();

    // 5b) n_terms above MAX_TERMS clamps to 8
    start_a = 1'b1; n_a = 4'd15;
    push_a(20'd36, 1'b0);
    tick();
    start_a = 1'b0;
    a_if.term_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_if.term_in = 16'(i);
      tick();
    end
    a_if.term_valid = 1'b0;
    check("t5_clamp_valid", 32'(a_if.sum_valid), 32'd1);
    check("t5_clamp_sum", 32'(a_if.sum_out), 32'd36);
    tick();

    // 4) overflow on the 16-bit instance
    t3[0] = 16'hFFFF; t3[1] = 16'h0002; t3[2] = 16'h0003;
`ifdef CONV_ACCUM_SAT_EN
    ovf_exp = 16'hFFFF;
`else
    ovf_exp = 16'h0004;
`endif
    start_b = 1'b1; n_b = 4'd3;
    push_b(20'(ovf_exp), 1'b1);
    tick();
    start_b = 1'b0;
    b_if.term_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_if.term_in = t3[i];
      tick();
    end
    b_if.term_valid = 1'b0;
    check("t4_ovf", 32'(b_if.ovf_out), 32'd1);
    check("t4_sum", 32'(b_if.sum_out), 32'(ovf_exp));
    tick();
    start_b = 1'b1; n_b = 4'd1;
    push_b(20'd5, 1'b0);
    tick();
    start_b = 1'b0;
    b_if.term_valid = 1'b1; b_if.term_in = 16'd5; tick();
    b_if.term_valid = 1'b0;
    check("t4_ovf_cleared", 32'(b_if.ovf_out), 32'd0);
    tick();

    // 6) reset mid-sample discards partial sum
    start_a = 1'b1; n_a = 4'd4;
    tick();
    start_a = 1'b0;
    a_if.term_valid = 1'b1; a_if.term_in = 16'd1; tick();
    a_if.term_in = 16'd2; tick();
    a_if.term_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t6_busy", 32'(busy_a), 32'd0);
    check("t6_term_ready", 32'(a_if.term_ready), 32'd0);
    check("t6_sum_valid", 32'(a_if.sum_valid), 32'd0);
    check("t6_sum_out", 32'(a_if.sum_out), 32'd0);
    rst = 1'b0;
    start_a = 1'b1; n_a = 4'd1;
    push_a(20'd7, 1'b0);
    tick();
    start_a = 1'b0;
    a_if.term_valid = 1'b1; a_if.term_in = 16'd7; tick();
    a_if.term_valid = 1'b0;
    check("t6_sum", 32'(a_if.sum_out), 32'd7);
    tick();
    tick();

    check("sb_a_drained", 32'(q_a.size()), 32'd0);
    check("sb_b_drained", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
